// File: rtl/simp_io_pkg.sv
// Shared definitions for the simpcpu memory-mapped I/O peripherals:
// console address map, STATUS bit layout and the UART transmitter state encoding.
package simp_io_pkg;

    localparam logic [15:0] CONSOLE_BASE = 16'h1000;

    localparam logic [15:0] REG_TXDATA = 16'd0;
    localparam logic [15:0] REG_STATUS = 16'd1;

    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_BUSY      = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

endpackage

// File: rtl/simp_fifo.sv
// Synchronous FIFO with a combinational head output (dout) and an occupancy count.
// The caller is responsible for never pushing when full unless popping in the same cycle.
module simp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rptr];
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/simp_uart_tx.sv
// Console output peripheral: decodes CPU writes to TXDATA/STATUS, buffers bytes
// in a FIFO and serialises them as 8N1 UART on txd.
module simp_uart_tx
    import simp_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = CONSOLE_BASE,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        wr,
    output logic [15:0] rdata,
    output logic        sel,
    output logic        txd,
    output logic        tx_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_txd, w_txd_nxt;
    logic          r_ovf;
    logic [15:0]   r_rdata;

    logic          w_hit_data, w_hit_stat;
    logic          w_push_req, w_push, w_pop;
    logic          w_ovf_set, w_ovf_clr;
    logic          w_full, w_empty, w_baud_end;
    logic [7:0]    w_dout;
    logic [AW:0]   w_count;
    logic [15:0]   w_status;
    logic          w_unused_hi;

    assign w_hit_data = (addr == BASE_ADDR + REG_TXDATA);
    assign w_hit_stat = (addr == BASE_ADDR + REG_STATUS);
    assign sel        = w_hit_data | w_hit_stat;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_req = wr & w_hit_data;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = wr & w_hit_stat & wdata[ST_OVF];
    assign w_unused_hi = ^wdata[15:8];

    simp_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wdata[7:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_status                          = '0;
        w_status[ST_FULL]                 = w_full;
        w_status[ST_EMPTY]                = w_empty;
        w_status[ST_BUSY]                 = (r_state != UART_IDLE);
        w_status[ST_OVF]                  = r_ovf;
        w_status[ST_COUNT_LSB +: (AW+1)]  = w_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
            r_rdata <= w_hit_stat ? w_status : '0;
        end
    end

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        if (r_state != UART_IDLE) begin
            w_baud_nxt = w_baud_end ? '0 : r_baud + 1'b1;
        end
        case (r_state)
            UART_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_dout;
                    w_txd_nxt   = 1'b0;
                    w_baud_nxt  = '0;
                    w_state_nxt = UART_START;
                end
            end
            UART_START: begin
                if (w_baud_end) begin
                    w_txd_nxt   = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = '0;
                    w_state_nxt = UART_DATA;
                end
            end
            UART_DATA: begin
                if (w_baud_end) begin
                    if (r_bit == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = UART_STOP;
                    end else begin
                        w_txd_nxt   = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 1'b1;
                    end
                end
            end
            UART_STOP: begin
                // Chain straight into the next start bit so back-to-back bytes have no gap.
                if (w_baud_end) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_dout;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = UART_START;
                    end else begin
                        w_state_nxt = UART_IDLE;
                    end
                end
            end
            default: w_state_nxt = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= UART_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    assign txd      = r_txd;
    assign rdata    = r_rdata;
    assign tx_empty = w_empty & (r_state == UART_IDLE);

endmodule

// File: tb/tb_simp_uart_tx.sv
// Directed bench for simp_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8; expected
// txd waveforms and STATUS words are hand-derived from the register map.
module tb_simp_uart_tx;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] rdata;
    logic        sel;
    logic        txd;
    logic        tx_empty;

    int unsigned n_vec;
    int unsigned n_mis;

    simp_uart_tx #(
        .BASE_ADDR    (16'h1000),
        .FIFO_DEPTH   (8),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .wr       (wr),
        .rdata    (rdata),
        .sel      (sel),
        .txd      (txd),
        .tx_empty (tx_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the edge that loads the frame; checks all 40 bit-cycles.
    task automatic expect_frame(input logic [7:0] b);
        logic exp_bit;
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       exp_bit = 1'b0;
            else if (k < 36) exp_bit = b[(k-4)/4];
            else             exp_bit = 1'b1;
            chk($sformatf("txd[%h].%0d", b, k), {15'd0, txd}, {15'd0, exp_bit});
            tick();
        end
    endtask

    initial begin
        logic seen_low;
        n_vec = 0;
        n_mis = 0;
        rst   = 1'b0;
        wr    = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txd",   {15'd0, txd},      16'd1);
        chk("rst_rdata", rdata,             16'h0000);
        chk("rst_empty", {15'd0, tx_empty}, 16'd1);
        chk("rst_sel",   {15'd0, sel},      16'd0);
        rst = 1'b1;
        tick();

        // Single byte 0x55
        addr = 16'h1000; wdata = 16'h0055; wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("single_pre_txd",   {15'd0, txd},      16'd1);
        chk("single_pre_empty", {15'd0, tx_empty}, 16'd0);
        tick();
        expect_frame(8'h55);
        chk("single_done_empty", {15'd0, tx_empty}, 16'd1);

        // Status read and sel decode while idle; write elsewhere is ignored
        addr = 16'h1001; wr = 1'b0;
        #1;
        chk("sel_status", {15'd0, sel}, 16'd1);
        tick();
        chk("rdata_idle_status", rdata, 16'h0002);
        addr = 16'h0200;
        #1;
        chk("sel_other", {15'd0, sel}, 16'd0);
        tick();
        chk("rdata_other", rdata, 16'h0000);
        addr = 16'h1000;
        #1;
        chk("sel_txdata", {15'd0, sel}, 16'd1);
        tick();
        chk("rdata_txdata", rdata, 16'h0000);
        addr = 16'h0200; wdata = 16'h00AA; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        chk("other_wr_txd",   {15'd0, txd},      16'd1);
        chk("other_wr_empty", {15'd0, tx_empty}, 16'd1);

        // Burst of 8 bytes: back-to-back frames, no gap
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    addr = 16'h1000; wdata = 16'h0041 + 16'(i); wr = 1'b1;
                    tick();
                end
                wr = 1'b0;
            end
            begin
                tick();
                tick();
                for (int i = 0; i < 8; i++) expect_frame(8'h41 + 8'(i));
            end
        join
        chk("burst_done_empty", {15'd0, tx_empty}, 16'd1);

        // Overflow: 10 writes while the first frame is in flight
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    addr = 16'h1000; wdata = 16'h0030 + 16'(i); wr = 1'b1;
                    tick();
                end
                wr = 1'b0; addr = 16'h1001;
                #1;
                chk("ovf_sel", {15'd0, sel}, 16'd1);
                tick();
                chk("ovf_status", rdata, 16'h080D);
                wdata = 16'h0008; wr = 1'b1;
                tick();
                wr = 1'b0;
                tick();
                chk("ovf_cleared", rdata, 16'h0805);
            end
            begin
                tick();
                tick();
                for (int i = 0; i < 9; i++) expect_frame(8'h30 + 8'(i));
            end
        join
        chk("ovf_done_empty", {15'd0, tx_empty}, 16'd1);
        addr = 16'h1001;
        tick();
        chk("ovf_final_status", rdata, 16'h0002);

        // Push exactly on the STOP-ending pop while full
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    addr = 16'h1000; wdata = 16'h0060 + 16'(i); wr = 1'b1;
                    tick();
                end
                wr = 1'b0;
                repeat (32) tick();
                addr = 16'h1000; wdata = 16'h0069; wr = 1'b1;
                tick();
                wr = 1'b0; addr = 16'h1001;
                tick();
                chk("pushpop_full_status", rdata, 16'h0805);
            end
            begin
                tick();
                tick();
                for (int i = 0; i < 10; i++) expect_frame(8'h60 + 8'(i));
            end
        join
        chk("pushpop_done_empty", {15'd0, tx_empty}, 16'd1);

        // Reset during DATA bit 3 of 0xA5 with more bytes queued
        for (int i = 0; i < 3; i++) begin
            addr = 16'h1000; wr = 1'b1;
            wdata = (i == 0) ? 16'h00A5 : ((i == 1) ? 16'h003C : 16'h007E);
            tick();
        end
        wr = 1'b0; addr = 16'h1001;
        repeat (16) tick();
        chk("mid_txd_bit3",  {15'd0, txd}, 16'd0);
        chk("mid_rdata_busy", rdata,       16'h0204);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_txd",   {15'd0, txd},      16'd1);
        chk("arst_empty", {15'd0, tx_empty}, 16'd1);
        chk("arst_rdata", rdata,             16'h0000);
        addr = 16'h1000; wdata = 16'h0011; wr = 1'b1;
        tick();
        tick();
        wr = 1'b0; addr = 16'h0000;
        rst = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!txd) seen_low = 1'b1;
        end
        chk("post_rst_no_frame", {15'd0, seen_low}, 16'd0);
        chk("post_rst_empty",    {15'd0, tx_empty}, 16'd1);
        addr = 16'h1001;
        tick();
        chk("post_rst_status", rdata, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
